// File: rtl/gate_truth_checker.sv
//==============================================================================
// Module      : gate_truth_checker
// Description : Exercises a 2-input combinational gate through all four input
//               combinations, lets each one settle for SETTLE_CYCLES cycles,
//               samples the gate output and compares it against EXP_TABLE.
//               Reports pass/fail, a mismatch count, the first failing
//               combination and, optionally, the observed truth table.
//
// Parameters  : SETTLE_CYCLES - settle cycles per combination (1..15)
//               EXP_TABLE     - expected y, bit[{a,b}] (default 4'b0111 = NAND)
//
// Ports       : clk       - clock, all state updates on rising edge
//               rst       - synchronous active-high reset
//               start     - run request, accepted only in IDLE
//               a_o, b_o  - drive inputs a and b of the gate under test
//               y_i       - output y of the gate under test
//               busy      - high while combinations are being driven/sampled
//               done      - one-cycle pulse at the end of a run
//               pass      - all four combinations matched EXP_TABLE
//               err_cnt   - number of mismatching combinations (0..4)
//               err_idx   - {a,b} of the first mismatch, 0 if none
//               obs_table - observed y per combination, bit[{a,b}]
//
// Build macro : GATE_CHK_OBS_LOG_EN - when defined, obs_table records the
//               sampled y_i per combination; otherwise it is tied to 0.
//
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module gate_truth_checker #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXP_TABLE     = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] err_idx,
    output logic [3:0] obs_table
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Terminal value of the settle counter; DRIVE lasts counts 0..last.
    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] c_idx_last    = 2'd3;

    state_t     state_q,   state_d;
    logic [1:0] idx_q,     idx_d;
    logic [3:0] cnt_q,     cnt_d;
    logic       pass_q,    pass_d;
    logic [2:0] err_cnt_q, err_cnt_d;
    logic [1:0] err_idx_q, err_idx_d;

`ifdef GATE_CHK_OBS_LOG_EN
    logic [3:0] obs_q, obs_d;
`endif

    logic w_mismatch;

    assign w_mismatch = (y_i != EXP_TABLE[idx_q]);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        err_idx_d = err_idx_q;
`ifdef GATE_CHK_OBS_LOG_EN
        obs_d     = obs_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_DRIVE;
                    idx_d     = 2'd0;
                    cnt_d     = 4'd0;
                    pass_d    = 1'b0;
                    err_cnt_d = 3'd0;
                    err_idx_d = 2'd0;
`ifdef GATE_CHK_OBS_LOG_EN
                    obs_d     = 4'b0000;
`endif
                end
            end

            ST_DRIVE: begin
                if (cnt_q == c_settle_last) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end

            ST_SAMPLE: begin
                if (w_mismatch) begin
                    err_cnt_d = err_cnt_q + 3'd1;
                    // Only the first failing combination is recorded.
                    if (err_cnt_q == 3'd0) begin
                        err_idx_d = idx_q;
                    end
                end
`ifdef GATE_CHK_OBS_LOG_EN
                obs_d[idx_q] = y_i;
`endif
                if (idx_q == c_idx_last) begin
                    state_d = ST_DONE;
                    // pass is resolved here so that it already includes the
                    // last comparison when done is presented.
                    pass_d  = (err_cnt_d == 3'd0);
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_DRIVE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= 4'd0;
            pass_q    <= 1'b0;
            err_cnt_q <= 3'd0;
            err_idx_q <= 2'd0;
`ifdef GATE_CHK_OBS_LOG_EN
            obs_q     <= 4'b0000;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            err_idx_q <= err_idx_d;
`ifdef GATE_CHK_OBS_LOG_EN
            obs_q     <= obs_d;
`endif
        end
    end

    // Status outputs are decoded from registered state only.
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done       = (state_q == ST_DONE);
    assign {a_o, b_o} = busy ? idx_q : 2'b00;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign err_idx    = err_idx_q;

`ifdef GATE_CHK_OBS_LOG_EN
    assign obs_table  = obs_q;
`else
    assign obs_table  = 4'b0000;
`endif

endmodule

`default_nettype wire

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 The parameter SETTLE_CYCLES SHALL have default 2 and set the settle cycles per input combination; legal range 1..15.
REQ-002 The parameter EXP_TABLE[3:0] SHALL have default 4'b0111 and give the expected gate output, where bit[{a,b}] is the value for that combination (default = NAND).
REQ-003 The port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be input, 1 bit: reset, synchronous and active-high.
REQ-005 The port start SHALL be input, 1 bit: run request, sampled on clk.
REQ-006 The port a_o SHALL be output, 1 bit: drives input a of the gate under test.
REQ-007 The port b_o SHALL be output, 1 bit: drives input b of the gate under test.
REQ-008 The port y_i SHALL be input, 1 bit: output y of the gate under test.
REQ-009 The port busy SHALL be output, 1 bit: high while a run is in progress.
REQ-010 The port done SHALL be output, 1 bit: one-cycle pulse at run end.
REQ-011 The port pass SHALL be output, 1 bit: high if all four combinations matched EXP_TABLE; valid from done until the next accepted start.
REQ-012 The port err_cnt SHALL be output, 3 bits: number of mismatching combinations, 0..4.
REQ-013 The port err_idx SHALL be output, 2 bits: {a,b} of the first mismatch; 0 when err_cnt=0.
REQ-014 The port obs_table SHALL be output, 4 bits: observed y per combination, bit[{a,b}].

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and DONE; a 2-bit combination index idx; and a 4-bit settle counter.
REQ-016 In IDLE with start=1, the block SHALL move to DRIVE with idx=0, clear pass/err_cnt/err_idx/obs_table, and set busy=1 from the next cycle.
REQ-017 start SHALL be ignored in DRIVE, SAMPLE and DONE, including when coincident with done.
REQ-018 In DRIVE and SAMPLE, {a_o,b_o} SHALL equal idx; in IDLE and DONE, a_o=b_o=0.
REQ-019 The block SHALL remain in DRIVE for exactly SETTLE_CYCLES cycles, then enter SAMPLE for exactly one cycle.
REQ-020 In SAMPLE, y_i SHALL be compared to EXP_TABLE[idx]; on mismatch err_cnt increments, and err_idx loads idx if err_cnt was 0.
REQ-021 From SAMPLE with idx<3, the block SHALL increment idx and return to DRIVE; with idx=3 it SHALL go to DONE, with no idx wrap-around observable.
REQ-022 In DONE, the block SHALL assert done=1 for one cycle, set pass=(err_cnt==0) including the final comparison, drop busy, then go to IDLE.
REQ-023 Latency: with start accepted at edge k, done SHALL be high in cycle k+1+4*(SETTLE_CYCLES+1); for the default this is k+13.
REQ-024 pass, err_cnt, err_idx and obs_table SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-025 While rst=1 at a clk edge, the state SHALL become IDLE, idx=0 and the counter=0.
REQ-026 While rst=1 at a clk edge, all outputs SHALL be 0: a_o, b_o, busy, done, pass, err_cnt, err_idx and obs_table.
REQ-027 rst SHALL override start when both are asserted in the same cycle.
REQ-028 rst asserted mid-run SHALL abort the run with no done pulse.

Configuration
REQ-029 With the macro GATE_CHK_OBS_LOG_EN defined, in SAMPLE obs_table[idx] SHALL capture y_i.
REQ-030 Without GATE_CHK_OBS_LOG_EN, the obs_table port SHALL exist but be tied to 4'b0000; all other behaviour is unchanged.

Verification
REQ-031 Ideal NAND on y_i, default parameters, start pulse: done is high 13 cycles later; pass=1, err_cnt=0, err_idx=0, and obs_table=4'b0111 (macro on) or 4'b0000 (macro off).
REQ-032 y_i stuck at 1, default EXP_TABLE: pass=0, err_cnt=1, err_idx=3.
REQ-033 y_i stuck at 0, default EXP_TABLE: pass=0, err_cnt=3, err_idx=0.
REQ-034 EXP_TABLE=4'b1000 with an AND model and SETTLE_CYCLES=1: done is high 9 cycles after start and pass=1.
REQ-035 Second start pulse 4 cycles into a run: it is ignored and exactly one done occurs. A start during DONE is also ignored. A start after returning to IDLE begins a new run.
REQ-036 rst asserted 5 cycles into a run: next cycle all outputs are 0 with no done. A subsequent start completes normally with pass=1.
